id_decode_stage: RTL and testbench
==================================

# id_decode_stage

RV32I instruction-decode stage sitting between instruction fetch and the execute stage. It drives the register-file read addresses and decodes each fetched instruction into operand, immediate and control fields. A 32-entry busy scoreboard stalls read-after-write and write-after-write hazards. Results are held in a one-deep output register with a valid/ready handshake toward EX.

## Interface
- No parameters; data width is 32, register address width is 5.
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- if_valid  in  1  fetch presents an instruction.
- if_instr  in  32  instruction word.
- if_pc  in  32  PC of if_instr.
- id_ready  out  1  stage accepts if_instr this cycle.
- rf_addr1, rf_addr2  out  5  register-file read addresses: rs1 = if_instr[19:15] and rs2 = if_instr[24:20], combinational.
- ex_valid  out  1  output register holds a decoded instruction.
- ex_ready  in  1  EX consumes the output this cycle.
- ex_pc  out  32  PC of the held instruction.
- ex_rs1, ex_rs2, ex_rd  out  5 each  decoded register indices.
- ex_imm  out  32  sign-extended immediate.
- ex_alu_op  out  4  encoding: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB.
- ex_use_imm  out  1  ALU operand B is the immediate.
- ex_reg_we, ex_mem_rd, ex_mem_wr, ex_branch, ex_jump  out  1 each  control flags.
- ex_illegal  out  1  unrecognised opcode or funct.
- wb_valid  in  1  writeback retires a register write.
- wb_rd  in  5  register being retired.
- flush  in  1  discard the held instruction and the one presented.

## Operation
- Accepted opcodes:
  - LUI 0110111: PASSB, U-immediate.
  - AUIPC 0010111: ADD, U-immediate.
  - JAL 1101111: J-immediate, jump.
  - JALR 1100111: I-immediate, jump.
  - BRANCH 1100011: B-immediate, SUB, branch.
  - LOAD 0000011: I-immediate, ADD, mem_rd.
  - STORE 0100011: S-immediate, ADD, mem_wr.
  - OP-IMM 0010011: I-immediate, alu_op from funct3; bit 30 selects SRA for funct3 = 101.
  - OP 0110011: alu_op from funct3, with funct7 bit 30 selecting SUB and SRA.
- Any other opcode, or a funct7 other than 0000000 / 0100000 where checked: ex_illegal = 1, and reg_we, mem_rd and mem_wr are forced to 0.
- reg_we = 1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM and OP, except when rd = 0, where reg_we is forced to 0.
- Operand usage:
  - rs1 is used by all formats except LUI, AUIPC and JAL.
  - rs2 is used only by BRANCH, STORE and OP.
- Scoreboard: busy[31:0], with busy[0] hardwired to 0.
  - hazard = (uses_rs1 & busy[rs1]) | (uses_rs2 & busy[rs2]) | (reg_we & busy[rd]).
  - Evaluated on registered busy only; a wb_valid in the same cycle does not release the stall until the next cycle.
- id_ready = !flush & !hazard & (!ex_valid | ex_ready).
- Accept = if_valid & id_ready. On accept, the output register loads all decoded fields, ex_valid is set, and busy[rd] is set if reg_we.
- When ex_valid & ex_ready & !accept, ex_valid is cleared. While ex_valid & !ex_ready, all ex_* outputs hold stable.
- Writeback: wb_valid clears busy[wb_rd]. If the same register is set by an accept in the same cycle, the set wins.
- Flush:
  - ex_valid is cleared.
  - If the held instruction had ex_reg_we, its busy[ex_rd] is cleared.
  - Busy bits of instructions already past EX are untouched.
  - id_ready = 0 for that cycle.
- Reset (asynchronous, rst_n low): ex_valid = 0, busy = 0, and every ex_* data and control output = 0. id_ready follows its equation, so it is 1 after reset with no hazard.

## Timing
- Latency: an instruction accepted on edge N appears on ex_* after edge N and is valid during cycle N+1.
- Throughput is one instruction per cycle with no hazards and ex_ready held high.
- rf_addr1 and rf_addr2 are combinational from if_instr, so read data is available to EX alongside ex_valid.
- A RAW dependency on the immediately preceding instruction stalls until its wb_valid has been registered: the minimum is one bubble after writeback.
- A flush asserted while ex_ready is high still discards the held instruction; EX must ignore ex_valid in the flush cycle.
- rst_n deasserted mid-stall returns the block to the empty state with no pending busy bits.

## Test plan
- Reset with if_valid = 0: ex_valid = 0, busy = 0, id_ready = 1. Then present ADDI x5,x0,7 (0x00700293) -> next cycle ex_rd = 5, ex_imm = 7, ex_alu_op = 0, ex_use_imm = 1, ex_reg_we = 1.
- ADDI x5 accepted, then ADD x6,x5,x5 presented -> id_ready = 0 until wb_valid with wb_rd = 5 is seen; ADD is accepted on the cycle after the writeback.
- ex_ready = 0 for 3 cycles with if_valid high -> id_ready = 0 and ex_* stable; ex_ready = 1 -> the next instruction loads on the same edge.
- Instruction word 0xFFFFFFFF -> ex_illegal = 1, reg_we = 0, and no busy bit set. SUB x1,x2,x3 -> ex_alu_op = 1. SRAI x1,x1,3 -> ex_alu_op = 7, ex_imm = 3.
- Flush while the held LW x9 is valid -> ex_valid = 0 next cycle, busy[9] = 0, and an instruction reading x9 is accepted without a stall.
- Accept ADDI x4 on the same cycle as wb_valid with wb_rd = 4 -> busy[4] remains 1.

Source files
------------

// File: rtl/id_decode_stage.sv
// RV32I decode stage: decodes the fetched word into EX control/operand fields,
// stalls RAW/WAW hazards via a busy scoreboard, and holds one result for EX.
module id_decode_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  output logic        id_ready,
  output logic [4:0]  rf_addr1,
  output logic [4:0]  rf_addr2,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [31:0] ex_pc,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [4:0]  ex_rd,
  output logic [31:0] ex_imm,
  output logic [3:0]  ex_alu_op,
  output logic        ex_use_imm,
  output logic        ex_reg_we,
  output logic        ex_mem_rd,
  output logic        ex_mem_wr,
  output logic        ex_branch,
  output logic        ex_jump,
  output logic        ex_illegal,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        flush
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic        use_imm;
    logic        reg_we;
    logic        mem_rd;
    logic        mem_wr;
    logic        branch;
    logic        jump;
    logic        illegal;
  } dec_t;

  // alt selects SUB for funct3=000 and SRA for funct3=101
  function automatic logic [3:0] f3_alu(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        f7_ok;
  logic        is_shift;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opc      = if_instr[6:0];
  assign f3       = if_instr[14:12];
  assign f7       = if_instr[31:25];
  assign f7_ok    = (f7 == 7'b0000000) || (f7 == 7'b0100000);
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

  assign imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
  assign imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
  assign imm_b = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25],
                  if_instr[11:8], 1'b0};
  assign imm_u = {if_instr[31:12], 12'b0};
  assign imm_j = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20],
                  if_instr[30:21], 1'b0};

  assign rf_addr1 = if_instr[19:15];
  assign rf_addr2 = if_instr[24:20];

  dec_t dec;
  logic uses_rs1, uses_rs2;

  always_comb begin
    dec      = '0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    dec.rs1  = if_instr[19:15];
    dec.rs2  = if_instr[24:20];
    dec.rd   = if_instr[11:7];
    case (opc)
      OPC_LUI: begin
        dec.imm = imm_u; dec.alu_op = ALU_PASSB; dec.use_imm = 1'b1; dec.reg_we = 1'b1;
      end
      OPC_AUIPC: begin
        dec.imm = imm_u; dec.alu_op = ALU_ADD; dec.use_imm = 1'b1; dec.reg_we = 1'b1;
      end
      OPC_JAL: begin
        dec.imm = imm_j; dec.use_imm = 1'b1; dec.jump = 1'b1; dec.reg_we = 1'b1;
      end
      OPC_JALR: begin
        dec.imm = imm_i; dec.use_imm = 1'b1; dec.jump = 1'b1; dec.reg_we = 1'b1;
        uses_rs1 = 1'b1;
      end
      OPC_BRANCH: begin
        dec.imm = imm_b; dec.alu_op = ALU_SUB; dec.branch = 1'b1;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OPC_LOAD: begin
        dec.imm = imm_i; dec.alu_op = ALU_ADD; dec.use_imm = 1'b1;
        dec.mem_rd = 1'b1; dec.reg_we = 1'b1; uses_rs1 = 1'b1;
      end
      OPC_STORE: begin
        dec.imm = imm_s; dec.alu_op = ALU_ADD; dec.use_imm = 1'b1; dec.mem_wr = 1'b1;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OPC_OPIMM: begin
        // shifts carry a zero-extended shamt; funct7 is only meaningful for them
        dec.imm     = is_shift ? {27'b0, if_instr[24:20]} : imm_i;
        dec.alu_op  = f3_alu(f3, (f3 == 3'b101) && if_instr[30]);
        dec.use_imm = 1'b1;
        dec.reg_we  = 1'b1;
        dec.illegal = is_shift && !f7_ok;
        uses_rs1    = 1'b1;
      end
      OPC_OP: begin
        dec.alu_op  = f3_alu(f3, if_instr[30]);
        dec.reg_we  = 1'b1;
        dec.illegal = !f7_ok;
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.illegal) begin
      dec.alu_op  = ALU_ADD;
      dec.use_imm = 1'b0;
      dec.reg_we  = 1'b0;
      dec.mem_rd  = 1'b0;
      dec.mem_wr  = 1'b0;
      dec.branch  = 1'b0;
      dec.jump    = 1'b0;
      uses_rs1    = 1'b0;
      uses_rs2    = 1'b0;
    end
    if (dec.rd == 5'd0) dec.reg_we = 1'b0;
  end

  logic [31:0] busy_q, busy_d;
  logic        ex_valid_q;
  logic [31:0] ex_pc_q;
  dec_t        ex_q;
  logic        hazard, accept;

  // hazard looks only at registered busy, so a same-cycle writeback still stalls
  assign hazard = (uses_rs1 & busy_q[dec.rs1]) |
                  (uses_rs2 & busy_q[dec.rs2]) |
                  (dec.reg_we & busy_q[dec.rd]);
  assign id_ready = !flush && !hazard && (!ex_valid_q || ex_ready);
  assign accept   = if_valid && id_ready;

  // set after clears so an accept beats a same-cycle writeback to the same rd
  always_comb begin
    busy_d = busy_q;
    if (wb_valid) busy_d[wb_rd] = 1'b0;
    if (flush && ex_valid_q && ex_q.reg_we) busy_d[ex_q.rd] = 1'b0;
    if (accept && dec.reg_we) busy_d[dec.rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      ex_valid_q <= 1'b0;
      ex_pc_q    <= '0;
      ex_q       <= '0;
    end else begin
      busy_q <= busy_d;
      if (accept) begin
        ex_valid_q <= 1'b1;
        ex_pc_q    <= if_pc;
        ex_q       <= dec;
      end else if (flush || ex_ready) begin
        ex_valid_q <= 1'b0;
      end
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_pc      = ex_pc_q;
  assign ex_rs1     = ex_q.rs1;
  assign ex_rs2     = ex_q.rs2;
  assign ex_rd      = ex_q.rd;
  assign ex_imm     = ex_q.imm;
  assign ex_alu_op  = ex_q.alu_op;
  assign ex_use_imm = ex_q.use_imm;
  assign ex_reg_we  = ex_q.reg_we;
  assign ex_mem_rd  = ex_q.mem_rd;
  assign ex_mem_wr  = ex_q.mem_wr;
  assign ex_branch  = ex_q.branch;
  assign ex_jump    = ex_q.jump;
  assign ex_illegal = ex_q.illegal;

endmodule

// File: tb/tb_id_decode_stage.sv
// Bench for id_decode_stage: directed scenarios then random traffic, all
// checked against a cycle-level behavioural model of decode + scoreboard.
module tb_id_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_instr, if_pc;
  logic        id_ready;
  logic [4:0]  rf_addr1, rf_addr2;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_pc;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [31:0] ex_imm;
  logic [3:0]  ex_alu_op;
  logic        ex_use_imm, ex_reg_we, ex_mem_rd, ex_mem_wr, ex_branch, ex_jump, ex_illegal;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;

  always #5 clk = ~clk;

  id_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .rf_addr1(rf_addr1), .rf_addr2(rf_addr2),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_imm(ex_imm),
    .ex_alu_op(ex_alu_op), .ex_use_imm(ex_use_imm), .ex_reg_we(ex_reg_we),
    .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_branch(ex_branch),
    .ex_jump(ex_jump), .ex_illegal(ex_illegal),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic        use_imm, we, mrd, mwr, br, jmp, ill;
  } mdec_t;

  localparam logic [3:0] F3ALU [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};

  int    n_tests = 0;
  int    n_fail  = 0;
  bit    m_valid;
  mdec_t m_ex;
  bit    m_busy [32];

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference decode written straight from the instruction-set rules
  function automatic mdec_t mdecode(input logic [31:0] w, input logic [31:0] pc,
                                    output bit u1, output bit u2);
    mdec_t d;
    logic signed [11:0] i12;
    logic signed [11:0] s12;
    logic signed [12:0] b13;
    logic signed [20:0] j21;
    int f3;
    bit b30, f7ok, shift;
    d = '0; u1 = 0; u2 = 0;
    i12 = w[31:20];
    s12 = {w[31:25], w[11:7]};
    b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0};
    j21 = {w[31], w[19:12], w[20], w[30:21], 1'b0};
    f3 = int'(w[14:12]);
    b30 = w[30];
    f7ok = (w[31:25] == 7'd0) || (w[31:25] == 7'd32);
    shift = (f3 == 1) || (f3 == 5);
    d.pc = pc; d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.rd = w[11:7];
    case (w[6:0])
      7'b0110111: begin d.imm = {w[31:12], 12'd0}; d.alu = 4'd10; d.use_imm = 1; d.we = 1; end
      7'b0010111: begin d.imm = {w[31:12], 12'd0}; d.alu = 4'd0;  d.use_imm = 1; d.we = 1; end
      7'b1101111: begin d.imm = 32'(j21); d.use_imm = 1; d.jmp = 1; d.we = 1; end
      7'b1100111: begin d.imm = 32'(i12); d.use_imm = 1; d.jmp = 1; d.we = 1; u1 = 1; end
      7'b1100011: begin d.imm = 32'(b13); d.alu = 4'd1; d.br = 1; u1 = 1; u2 = 1; end
      7'b0000011: begin d.imm = 32'(i12); d.use_imm = 1; d.mrd = 1; d.we = 1; u1 = 1; end
      7'b0100011: begin d.imm = 32'(s12); d.use_imm = 1; d.mwr = 1; u1 = 1; u2 = 1; end
      7'b0010011: begin
        d.imm = shift ? 32'(w[24:20]) : 32'(i12);
        d.alu = (f3 == 5 && b30) ? 4'd7 : F3ALU[f3];
        d.use_imm = 1; d.we = 1; u1 = 1;
        d.ill = shift && !f7ok;
      end
      7'b0110011: begin
        d.alu = (f3 == 0 && b30) ? 4'd1 : (f3 == 5 && b30) ? 4'd7 : F3ALU[f3];
        d.we = 1; u1 = 1; u2 = 1;
        d.ill = !f7ok;
      end
      default: d.ill = 1;
    endcase
    if (d.ill) begin
      d.alu = 0; d.use_imm = 0; d.we = 0; d.mrd = 0; d.mwr = 0; d.br = 0; d.jmp = 0;
      u1 = 0; u2 = 0;
    end
    if (d.rd == 0) d.we = 0;
    return d;
  endfunction

  function automatic mdec_t dut_ex();
    return {ex_pc, ex_rs1, ex_rs2, ex_rd, ex_imm, ex_alu_op, ex_use_imm, ex_reg_we,
            ex_mem_rd, ex_mem_wr, ex_branch, ex_jump, ex_illegal};
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_ex = '0;
    for (int r = 0; r < 32; r++) m_busy[r] = 0;
  endtask

  // Called just after a negedge: apply inputs, let combinational outputs settle
  task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input bit er, input bit wv, input logic [4:0] wr, input bit fl);
    if_valid = v; if_instr = ins; if_pc = pc; ex_ready = er;
    wb_valid = wv; wb_rd = wr; flush = fl;
    #1;
  endtask

  // Check the cycle against the model, advance the model, clock once
  task automatic step();
    mdec_t d;
    bit u1, u2, haz, rdy, acc;
    d = mdecode(if_instr, if_pc, u1, u2);
    haz = (u1 && m_busy[d.rs1]) || (u2 && m_busy[d.rs2]) || (d.we && m_busy[d.rd]);
    rdy = !flush && !haz && (!m_valid || ex_ready);
    acc = if_valid && rdy;
    chk("id_ready", 96'(id_ready), 96'(rdy));
    chk("rf_addr", 96'({rf_addr1, rf_addr2}), 96'({if_instr[19:15], if_instr[24:20]}));
    chk("ex_valid", 96'(ex_valid), 96'(m_valid));
    chk("ex_fields", 96'(dut_ex()), 96'(m_ex));
    if (wb_valid) m_busy[wb_rd] = 0;
    if (flush && m_valid && m_ex.we) m_busy[m_ex.rd] = 0;
    if (acc && d.we) m_busy[d.rd] = 1;
    m_busy[0] = 0;
    if (acc) begin
      m_valid = 1; m_ex = d;
    end else if (flush || ex_ready) begin
      m_valid = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r, w;
    logic [4:0]  rd, rs1, rs2;
    logic [6:0]  f7;
    logic [2:0]  f3;
    int k;
    r   = $urandom;
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    f3  = r[14:12];
    k   = $urandom_range(0, 3);
    f7  = (k == 0) ? 7'd0 : (k == 1) ? 7'd32 : (k == 2) ? 7'd0 : r[31:25];
    case ($urandom_range(0, 11))
      0:       w = {r[31:12], rd, 7'b0110111};
      1:       w = {r[31:12], rd, 7'b0010111};
      2:       w = {r[31:12], rd, 7'b1101111};
      3:       w = {r[31:20], rs1, 3'b000, rd, 7'b1100111};
      4:       w = {r[31:25], rs2, rs1, f3, r[11:7], 7'b1100011};
      5:       w = {r[31:20], rs1, f3, rd, 7'b0000011};
      6:       w = {r[31:25], rs2, rs1, f3, r[11:7], 7'b0100011};
      7, 11:   w = {f7, r[24:20], rs1, f3, rd, 7'b0010011};
      8, 9:    w = {f7, rs2, rs1, f3, rd, 7'b0110011};
      default: w = r;
    endcase
    return w;
  endfunction

  localparam logic [31:0] ADDI5  = 32'h00700293; // addi x5,x0,7
  localparam logic [31:0] ADD6   = 32'h00528333; // add  x6,x5,x5
  localparam logic [31:0] SUB1   = 32'h403100B3; // sub  x1,x2,x3
  localparam logic [31:0] ADD7   = 32'h01FF83B3; // add  x7,x31,x31
  localparam logic [31:0] SRAI1  = 32'h4030D093; // srai x1,x1,3
  localparam logic [31:0] LW9    = 32'h0000A483; // lw   x9,0(x1)
  localparam logic [31:0] ADDI10 = 32'h00148513; // addi x10,x9,1
  localparam logic [31:0] ADDI4  = 32'h00100213; // addi x4,x0,1
  localparam logic [31:0] ADD11  = 32'h000205B3; // add  x11,x4,x0

  initial begin
    rst_n = 1'b0;
    drive(0, 32'h0, 32'h0, 1, 0, 5'd0, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ex_valid", 96'(ex_valid), 96'd0);
    chk("rst_id_ready", 96'(id_ready), 96'd1);
    chk("rst_ex_fields", 96'(dut_ex()), 96'd0);

    drive(1, ADDI5, 32'h100, 1, 0, 5'd0, 0); step();
    chk("addi_valid", 96'(ex_valid), 96'd1);
    chk("addi_fields", 96'({ex_rd, ex_imm, ex_alu_op, ex_use_imm, ex_reg_we}),
        96'({5'd5, 32'd7, 4'd0, 1'b1, 1'b1}));

    drive(1, ADD6, 32'h104, 1, 0, 5'd0, 0);
    chk("raw_stall", 96'(id_ready), 96'd0); step();
    drive(1, ADD6, 32'h104, 1, 1, 5'd5, 0);
    chk("raw_wb_same_cycle", 96'(id_ready), 96'd0); step();
    drive(1, ADD6, 32'h104, 1, 0, 5'd0, 0);
    chk("raw_release", 96'(id_ready), 96'd1); step();
    chk("raw_accepted", 96'({ex_valid, ex_rd}), 96'({1'b1, 5'd6}));

    for (int i = 0; i < 3; i++) begin
      drive(1, SUB1, 32'h108, 0, 0, 5'd0, 0);
      chk("bp_stall", 96'(id_ready), 96'd0); step();
      chk("bp_hold", 96'({ex_valid, ex_pc, ex_rd}), 96'({1'b1, 32'h104, 5'd6}));
    end
    drive(1, SUB1, 32'h108, 1, 0, 5'd0, 0);
    chk("bp_release", 96'(id_ready), 96'd1); step();
    chk("sub_alu", 96'({ex_pc, ex_alu_op}), 96'({32'h108, 4'd1}));

    drive(1, 32'hFFFFFFFF, 32'h10C, 1, 0, 5'd0, 0); step();
    chk("illegal", 96'({ex_valid, ex_illegal, ex_reg_we, ex_mem_rd, ex_mem_wr}),
        96'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
    drive(1, ADD7, 32'h110, 1, 0, 5'd0, 0);
    chk("illegal_no_busy", 96'(id_ready), 96'd1); step();

    drive(0, 32'h0, 32'h0, 1, 1, 5'd1, 0); step();
    drive(1, SRAI1, 32'h114, 1, 0, 5'd0, 0); step();
    chk("srai", 96'({ex_alu_op, ex_imm}), 96'({4'd7, 32'd3}));

    drive(0, 32'h0, 32'h0, 1, 1, 5'd1, 0); step();
    drive(1, LW9, 32'h118, 0, 0, 5'd0, 0); step();
    chk("lw_held", 96'({ex_valid, ex_mem_rd, ex_rd}), 96'({1'b1, 1'b1, 5'd9}));
    drive(1, ADDI10, 32'h11C, 1, 0, 5'd0, 1);
    chk("flush_ready", 96'(id_ready), 96'd0); step();
    chk("flush_valid", 96'(ex_valid), 96'd0);
    drive(1, ADDI10, 32'h11C, 1, 0, 5'd0, 0);
    chk("flush_no_stall", 96'(id_ready), 96'd1); step();
    chk("flush_next", 96'({ex_valid, ex_rd}), 96'({1'b1, 5'd10}));

    drive(1, ADDI4, 32'h120, 1, 1, 5'd4, 0); step();
    drive(1, ADD11, 32'h124, 1, 0, 5'd0, 0);
    chk("set_beats_wb", 96'(id_ready), 96'd0); step();

    for (int r = 1; r < 32; r++) begin
      drive(0, 32'h0, 32'h0, 1, 1, 5'(r), 0); step();
    end

    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 9) < 8, rnd_instr(), $urandom, $urandom_range(0, 9) < 7,
            $urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)), $urandom_range(0, 19) == 0);
      step();
    end

    drive(0, 32'h0, 32'h0, 1, 0, 5'd0, 0); step();
    drive(1, ADDI5, 32'h200, 1, 0, 5'd0, 0); step();
    drive(1, ADD6, 32'h204, 1, 0, 5'd0, 0);
    chk("rst_mid_stall_pre", 96'(id_ready), 96'd0);
    rst_n = 1'b0;
    #2;
    model_reset();
    chk("rst_mid_valid", 96'(ex_valid), 96'd0);
    chk("rst_mid_ready", 96'(id_ready), 96'd1);
    rst_n = 1'b1;
    step();
    chk("rst_mid_accept", 96'({ex_valid, ex_rd, ex_pc}), 96'({1'b1, 5'd6, 32'h204}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
